score_mult_arbiter: RTL and testbench

//   Shares one shift-add constant multiplier between the two score requesters of
//   the end-of-game scoring path: time penalty and discovered-pairs penalty.

---
 rtl/score_mult_arbiter.sv | 108 ++++++++++
 tb/tb_score_mult_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_mult_arbiter.sv
// Shared shift-add constant multiplier for the end-of-game score path.
// Two requesters (time penalty, discovered-pairs penalty) are served one at a
// time with round-robin arbitration. Each op is OP_W MUL cycles plus one DONE
// cycle. The result and the done pulse are both visible during DONE.
module score_mult_arbiter #(
  parameter int WEIGHT = 101,
  parameter int OP_W   = 6,
  parameter int RES_W  = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_time,
  input  logic [OP_W-1:0]  time_op,
  input  logic             req_pairs,
  input  logic [OP_W-1:0]  pairs_op,
  output logic             busy,
  output logic             done_time,
  output logic             done_pairs,
  output logic [RES_W-1:0] mult_time_result,
  output logic [RES_W-1:0] mult_pairs_result
);

  localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);
  localparam logic [RES_W-1:0] WEIGHT_R = RES_W'(WEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_sh_q, op_sh_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_pairs_q, gnt_pairs_d;    // 1: pairs owns the multiplier
  logic             last_pairs_q, last_pairs_d;  // 1: pairs was granted last
  logic [RES_W-1:0] res_time_q, res_time_d;
  logic [RES_W-1:0] res_pairs_q, res_pairs_d;
  logic [RES_W-1:0] addend;

  // State and datapath registers; reset drops any partial product
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_sh_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      gnt_pairs_q  <= 1'b0;
      last_pairs_q <= 1'b1;
      res_time_q   <= '0;
      res_pairs_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_sh_q      <= op_sh_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      gnt_pairs_q  <= gnt_pairs_d;
      last_pairs_q <= last_pairs_d;
      res_time_q   <= res_time_d;
      res_pairs_q  <= res_pairs_d;
    end
  end

  // Arbitration, shift-add iteration and result write-back
  always_comb begin
    state_d      = state_q;
    op_sh_d      = op_sh_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    gnt_pairs_d  = gnt_pairs_q;
    last_pairs_d = last_pairs_q;
    res_time_d   = res_time_q;
    res_pairs_d  = res_pairs_q;
    addend       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_time || req_pairs) begin
          // Both asking: the one not served last wins
          gnt_pairs_d  = (req_time && req_pairs) ? ~last_pairs_q : req_pairs;
          op_sh_d      = gnt_pairs_d ? pairs_op : time_op;
          acc_d        = '0;
          cnt_d        = '0;
          last_pairs_d = gnt_pairs_d;
          state_d      = S_MUL;
        end
      end
      S_MUL: begin
        addend  = op_sh_q[0] ? (WEIGHT_R << cnt_q) : '0;
        acc_d   = acc_q + addend;
        op_sh_d = op_sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Write the final sum now so it is visible alongside the done pulse
          if (gnt_pairs_q) res_pairs_d = acc_d;
          else             res_time_d  = acc_d;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy              = (state_q != S_IDLE);
  assign done_time         = (state_q == S_DONE) && !gnt_pairs_q;
  assign done_pairs        = (state_q == S_DONE) &&  gnt_pairs_q;
  assign mult_time_result  = res_time_q;
  assign mult_pairs_result = res_pairs_q;

endmodule

// File: tb/tb_score_mult_arbiter.sv
// Self-checking bench for score_mult_arbiter: directed scenarios plus a
// randomized round-robin run against a transaction-level model.
module tb_score_mult_arbiter;
  localparam int W = 101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_time = 1'b0, req_pairs = 1'b0;
  logic [5:0]  time_op = '0, pairs_op = '0;
  logic        busy, done_time, done_pairs;
  logic [12:0] mtr, mpr;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: who was served last (1 = pairs) and held results
  bit          m_last_pairs;
  logic [12:0] m_res_t, m_res_p;

  score_mult_arbiter dut (
    .clk(clk), .rst(rst),
    .req_time(req_time), .time_op(time_op),
    .req_pairs(req_pairs), .pairs_op(pairs_op),
    .busy(busy), .done_time(done_time), .done_pairs(done_pairs),
    .mult_time_result(mtr), .mult_pairs_result(mpr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, wanted summary before it");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [12:0] prod(input logic [5:0] op);
    int p;
    p = int'(op) * W;
    return p[12:0];
  endfunction

  task automatic do_reset;
    rst = 1'b1; req_time = 1'b0; req_pairs = 1'b0;
    tick(); tick();
    rst = 1'b0;
    m_last_pairs = 1'b1; m_res_t = '0; m_res_p = '0;
  endtask

  // Advance until a done pulse or budget expiry; cyc = cycles waited
  task automatic wait_done(input int budget, output int cyc, output bit dt, output bit dp);
    cyc = 0; dt = 0; dp = 0;
    while (cyc < budget && !dt && !dp) begin
      tick(); cyc++;
      dt = done_time; dp = done_pairs;
    end
  endtask

  // One request from one side; optional operand change / req drop mid-op
  task automatic run_one(input bit p, input logic [5:0] op, input int chg_cyc,
                         input logic [5:0] op2, input int drop_cyc,
                         output int cyc, output bit dt, output bit dp);
    if (p) begin pairs_op = op; req_pairs = 1'b1; end
    else   begin time_op  = op; req_time  = 1'b1; end
    cyc = 0; dt = 0; dp = 0;
    while (cyc < 20 && !dt && !dp) begin
      tick(); cyc++;
      if (cyc == chg_cyc) begin if (p) pairs_op = op2; else time_op = op2; end
      if (cyc == drop_cyc) begin if (p) req_pairs = 1'b0; else req_time = 1'b0; end
      dt = done_time; dp = done_pairs;
    end
    req_time = 1'b0; req_pairs = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if ({busy, done_time, done_pairs} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done_time, done_pairs});
    end
    n_cmp++;
    if (mtr !== 13'd0 || mpr !== 13'd0) begin
      n_err++; $display("FAIL reset_results: got %0d/%0d want 0/0", mtr, mpr);
    end
  endtask

  // Single time request, cycle-exact latency check
  task automatic test_basic(input logic [5:0] op);
    int bad_busy, bad_done;
    logic [12:0] ev;
    bad_busy = 0; bad_done = 0;
    ev = prod(op);
    time_op = op; req_time = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (busy !== 1'b1) bad_busy++;
      if (done_time !== (k == 7) || done_pairs !== 1'b0) bad_done++;
      if (k == 7) begin
        n_cmp++;
        if (mtr !== ev) begin n_err++; $display("FAIL basic_result: got %0d want %0d", mtr, ev); end
      end
    end
    req_time = 1'b0;
    m_last_pairs = 1'b0; m_res_t = ev;
    n_cmp++;
    if (bad_busy != 0) begin n_err++; $display("FAIL basic_busy: got %0d low cycles want 0", bad_busy); end
    n_cmp++;
    if (bad_done != 0) begin n_err++; $display("FAIL basic_done: got %0d wrong cycles want 0", bad_done); end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_both_first;
    int c; bit dt, dp;
    do_reset();
    time_op = 6'd33; pairs_op = 6'd5; req_time = 1'b1; req_pairs = 1'b1;
    wait_done(20, c, dt, dp);
    n_cmp++;
    if (c != 7 || !dt || dp) begin
      n_err++; $display("FAIL both_first_done: got cyc=%0d t=%b p=%b want cyc=7 t=1 p=0", c, dt, dp);
    end
    n_cmp++;
    if (mtr !== 13'd3333) begin n_err++; $display("FAIL both_first_val: got %0d want 3333", mtr); end
    req_time = 1'b0;
    wait_done(20, c, dt, dp);
    req_pairs = 1'b0;
    n_cmp++;
    if (!dp || dt || c < 8 || c > 9) begin
      n_err++; $display("FAIL both_second_done: got cyc=+%0d t=%b p=%b want +8..9 t=0 p=1", c, dt, dp);
    end
    n_cmp++;
    if (mpr !== 13'd505 || mtr !== 13'd3333) begin
      n_err++; $display("FAIL both_second_val: got %0d/%0d want 3333/505", mtr, mpr);
    end
    tick(); tick();
  endtask

  task automatic test_alternate;
    int c; bit dt, dp, exp_p;
    logic [5:0] ot, op;
    int bad;
    bad = 0;
    do_reset();
    ot = 6'($urandom_range(1, 63)); op = 6'($urandom_range(1, 63));
    time_op = ot; pairs_op = op; req_time = 1'b1; req_pairs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_p = (i % 2) == 1;
      wait_done(20, c, dt, dp);
      if (i == 3) begin req_time = 1'b0; req_pairs = 1'b0; end
      if (dp !== exp_p || dt !== !exp_p) bad++;
      if (exp_p ? (mpr !== prod(op)) : (mtr !== prod(ot))) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL alternate: got %0d bad grants/results want 0", bad); end
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL alternate_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_boundary;
    int c; bit dt, dp;
    do_reset();
    run_one(1'b0, 6'd63, 0, 6'd0, 0, c, dt, dp);
    n_cmp++;
    if (!dt || mtr !== 13'd6363) begin n_err++; $display("FAIL bound_t63: got %0d done=%b want 6363 done=1", mtr, dt); end
    run_one(1'b0, 6'd0, 0, 6'd0, 0, c, dt, dp);
    n_cmp++;
    if (!dt || c != 7 || mtr !== 13'd0) begin
      n_err++; $display("FAIL bound_t0: got %0d done=%b cyc=%0d want 0 done=1 cyc=7", mtr, dt, c);
    end
    run_one(1'b1, 6'd63, 0, 6'd0, 0, c, dt, dp);
    n_cmp++;
    if (!dp || mpr !== 13'd6363 || mtr !== 13'd0) begin
      n_err++; $display("FAIL bound_p63: got %0d/%0d want 0/6363", mtr, mpr);
    end
    run_one(1'b0, 6'd45, 3, 6'd17, 0, c, dt, dp);
    n_cmp++;
    if (!dt || mtr !== 13'd4545) begin n_err++; $display("FAIL op_change: got %0d want 4545", mtr); end
  endtask

  task automatic test_reset_mid;
    int c, bad; bit dt, dp;
    bad = 0;
    do_reset();
    run_one(1'b0, 6'd50, 0, 6'd0, 0, c, dt, dp);
    run_one(1'b1, 6'd7, 0, 6'd0, 0, c, dt, dp);
    n_cmp++;
    if (mtr !== 13'd5050 || mpr !== 13'd707) begin
      n_err++; $display("FAIL premid_vals: got %0d/%0d want 5050/707", mtr, mpr);
    end
    time_op = 6'd20; req_time = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0; req_time = 1'b0;
    m_last_pairs = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || mtr !== 13'd0 || mpr !== 13'd0) begin
      n_err++; $display("FAIL mid_reset: got busy=%b %0d/%0d want 0 0/0", busy, mtr, mpr);
    end
    for (int k = 0; k < 8; k++) begin
      if (done_time !== 1'b0 || done_pairs !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL mid_reset_quiet: got %0d active cycles want 0", bad); end
    test_basic(6'd20);
  endtask

  task automatic test_drop;
    int c, bad; bit dt, dp;
    bad = 0;
    do_reset();
    run_one(1'b1, 6'd10, 0, 6'd0, 2, c, dt, dp);
    n_cmp++;
    if (!dp || dt || c != 7 || mpr !== 13'd1010) begin
      n_err++; $display("FAIL drop: got cyc=%0d p=%b val=%0d want cyc=7 p=1 val=1010", c, dp, mpr);
    end
    for (int k = 0; k < 5; k++) begin
      if (busy !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL drop_idle: got %0d busy cycles want 0", bad); end
  endtask

  // Random request patterns; model picks the winner by round-robin rules
  task automatic test_random;
    bit rt, rp, w, dt, dp;
    int c;
    logic [5:0] ot, op;
    logic [12:0] ev;
    do_reset();
    rt = 0; rp = 0; ot = '0; op = '0;
    for (int r = 0; r < 24; r++) begin
      if (!rt && ($urandom % 2) == 1) begin rt = 1; ot = 6'($urandom); end
      if (!rp && ($urandom % 2) == 1) begin rp = 1; op = 6'($urandom); end
      if (!rt && !rp) begin rt = 1; ot = 6'($urandom); end
      time_op = ot; pairs_op = op; req_time = rt; req_pairs = rp;
      w = (rt && rp) ? !m_last_pairs : rp;
      m_last_pairs = w;
      ev = prod(w ? op : ot);
      tick(); tick();
      // Winner's operand is already captured; disturb it and maybe drop its req
      if (w) pairs_op = 6'($urandom); else time_op = 6'($urandom);
      if (($urandom % 4) == 0) begin
        if (w) begin rp = 0; req_pairs = 1'b0; end
        else   begin rt = 0; req_time  = 1'b0; end
      end
      wait_done(20, c, dt, dp);
      if (w) m_res_p = ev; else m_res_t = ev;
      n_cmp++;
      if (dt === dp || dp !== w) begin
        n_err++; $display("FAIL rand_grant r=%0d: got t=%b p=%b want p=%b", r, dt, dp, w);
      end
      n_cmp++;
      if (mtr !== m_res_t || mpr !== m_res_p) begin
        n_err++; $display("FAIL rand_result r=%0d: got %0d/%0d want %0d/%0d", r, mtr, mpr, m_res_t, m_res_p);
      end
      if (w) rp = 0; else rt = 0;
      req_time = rt; req_pairs = rp;
    end
    req_time = 1'b0; req_pairs = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic(6'd20);
    test_both_first();
    test_alternate();
    test_boundary();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
